// File: rtl/acc_alu_seq.sv
// acc_alu_seq
// Clocked accumulator ALU. Holds the accumulator R0, the carry flag and the
// unsigned compare flags. Single-cycle ops finish on the accepting edge.
// Shifts by N and an unsigned multiply run over several cycles behind a
// START/BUSY/DONE handshake.
//
// Ports
//   CLK     : clock, rising edge
//   RESET   : synchronous, active-high reset
//   START   : issue OP this cycle (taken only while idle)
//   OP      : 4-bit operation code
//   SET     : load R0 from SETNUM (taken only while idle, beats START)
//   SETNUM  : immediate for SET
//   INPUT   : second operand, sampled on the accepting edge only
//   OUT     : registered result, follows R0 after each R0-writing op
//   HI      : upper half of the last MUL product
//   SC_OUT  : registered carry flag
//   ZERO    : combinational R0 == 0
//   EQ/LT/GT: registered unsigned compare of R0 against INPUT (CMP only)
//   BUSY    : a multi-cycle op is in progress
//   DONE    : one-cycle pulse when an op's result becomes visible
module acc_alu_seq #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [3:0]   OP,
  input  logic         SET,
  input  logic [W-1:0] SETNUM,
  input  logic [W-1:0] INPUT,
  output logic [W-1:0] OUT,
  output logic [W-1:0] HI,
  output logic         SC_OUT,
  output logic         ZERO,
  output logic         EQ,
  output logic         LT,
  output logic         GT,
  output logic         BUSY,
  output logic         DONE
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] N_MAX = CW'(W);
  localparam logic [W-1:0]  W_LIM = W'(W);

  localparam logic [3:0] OP_MOVE   = 4'd1;
  localparam logic [3:0] OP_ASSIGN = 4'd2;
  localparam logic [3:0] OP_ADD    = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_AND    = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_LSL1   = 4'd7;
  localparam logic [3:0] OP_LSR1   = 4'd8;
  localparam logic [3:0] OP_SHLN   = 4'd9;
  localparam logic [3:0] OP_SHRN   = 4'd10;
  localparam logic [3:0] OP_MUL    = 4'd11;
  localparam logic [3:0] OP_CMP    = 4'd12;
  localparam logic [3:0] OP_CLRC   = 4'd13;
  localparam logic [3:0] OP_SETC   = 4'd14;

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {K_SHL, K_SHR, K_MUL} kind_t;

  state_t state, state_next;

  // Architectural registers
  logic [W-1:0] r0, out_q, hi_q;
  logic         c_q, eq_q, lt_q, gt_q, done_q;

  // Shadow registers used while a multi-cycle op runs; acc_lo doubles as
  // the shift register and as the low product half / remaining multiplier.
  logic [W-1:0]  acc_lo, acc_hi, mcand;
  logic          sh_c;
  kind_t         kind;
  logic [CW-1:0] cnt;

  logic          accept_set, accept_start, is_shift, start_multi, last_step;
  logic [CW-1:0] shift_n;
  logic [W:0]    add_res, sub_res, mul_sum;
  logic [W-1:0]  step_lo, step_hi;
  logic          step_c;

  // Acceptance decode and single-cycle arithmetic. SET wins over START, and
  // nothing is accepted outside IDLE. The shift count saturates at W.
  always_comb begin
    accept_set   = (state == IDLE) && SET;
    accept_start = (state == IDLE) && START && !SET;
    is_shift     = (OP == OP_SHLN) || (OP == OP_SHRN);
    shift_n      = (INPUT >= W_LIM) ? N_MAX : INPUT[CW-1:0];
    start_multi  = accept_start && ((is_shift && (shift_n != '0)) || (OP == OP_MUL));
    last_step    = (cnt == CW'(1));
    add_res      = {1'b0, r0} + {1'b0, INPUT} + {{W{1'b0}}, c_q};
    sub_res      = {1'b0, r0} + {1'b0, ~INPUT} + {{W{1'b0}}, 1'b1};
  end

  // One step of the running multi-cycle op. The multiply is the classic
  // shift-add: add the multiplicand to the high half when the current
  // multiplier bit is set, then shift the whole product right by one.
  always_comb begin
    step_lo = acc_lo;
    step_hi = acc_hi;
    step_c  = sh_c;
    mul_sum = '0;
    case (kind)
      K_SHL: begin
        step_lo = {acc_lo[W-2:0], 1'b0};
        step_c  = acc_lo[W-1];
      end
      K_SHR: begin
        step_lo = {1'b0, acc_lo[W-1:1]};
        step_c  = acc_lo[0];
      end
      default: begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        step_hi = mul_sum[W:1];
        step_lo = {mul_sum[0], acc_lo[W-1:1]};
        step_c  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: leave IDLE only for a multi-cycle op with real work,
  // return once the final step has been taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_multi) state_next = EXEC;
      EXEC:    if (last_step)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY   = (state == EXEC);
    ZERO   = (r0 == '0);
    OUT    = out_q;
    HI     = hi_q;
    SC_OUT = c_q;
    EQ     = eq_q;
    LT     = lt_q;
    GT     = gt_q;
    DONE   = done_q;
  end

  // Datapath. In IDLE single-cycle ops commit immediately and multi-cycle
  // ops load the shadow registers. In EXEC only the shadows move until the
  // last step, when R0/OUT/C (and HI for MUL) are written in one go.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r0     <= '0;
      out_q  <= '0;
      hi_q   <= '0;
      c_q    <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      gt_q   <= 1'b0;
      done_q <= 1'b0;
      acc_lo <= '0;
      acc_hi <= '0;
      mcand  <= '0;
      sh_c   <= 1'b0;
      kind   <= K_SHL;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (accept_set) begin
          r0 <= SETNUM;
        end else if (accept_start) begin
          done_q <= !start_multi;
          case (OP)
            OP_MOVE: begin
              r0    <= INPUT;
              out_q <= INPUT;
            end
            OP_ASSIGN: out_q <= r0;
            OP_ADD: begin
              {c_q, r0} <= add_res;
              out_q     <= add_res[W-1:0];
            end
            OP_SUB: begin
              {c_q, r0} <= sub_res;
              out_q     <= sub_res[W-1:0];
            end
            OP_AND: begin
              r0    <= r0 & INPUT;
              out_q <= r0 & INPUT;
            end
            OP_XOR: begin
              r0    <= r0 ^ INPUT;
              out_q <= r0 ^ INPUT;
            end
            OP_LSL1: begin
              {c_q, r0} <= {r0, c_q};
              out_q     <= {r0[W-2:0], c_q};
            end
            OP_LSR1: begin
              {r0, c_q} <= {c_q, r0};
              out_q     <= {c_q, r0[W-1:1]};
            end
            OP_SHLN, OP_SHRN: begin
              if (shift_n != '0) begin
                acc_lo <= r0;
                sh_c   <= c_q;
                cnt    <= shift_n;
                kind   <= (OP == OP_SHLN) ? K_SHL : K_SHR;
              end
            end
            OP_MUL: begin
              acc_lo <= r0;
              acc_hi <= '0;
              mcand  <= INPUT;
              cnt    <= N_MAX;
              kind   <= K_MUL;
            end
            OP_CMP: begin
              eq_q <= (r0 == INPUT);
              lt_q <= (r0 <  INPUT);
              gt_q <= (r0 >  INPUT);
            end
            OP_CLRC: c_q <= 1'b0;
            OP_SETC: c_q <= 1'b1;
            default: ;
          endcase
        end
      end else begin
        acc_lo <= step_lo;
        acc_hi <= step_hi;
        sh_c   <= step_c;
        cnt    <= cnt - CW'(1);
        if (last_step) begin
          r0     <= step_lo;
          out_q  <= step_lo;
          c_q    <= step_c;
          done_q <= 1'b1;
          if (kind == K_MUL) hi_q <= step_hi;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_alu_seq.sv
// tb_acc_alu_seq
// Bench for acc_alu_seq at W=8. A behavioural model computes every op's
// result with plain integer arithmetic at acceptance and holds multi-cycle
// results back for N cycles; a compare process checks all outputs against
// it on every falling edge. Directed sequences with literal expectations
// pin the model, then randomized traffic exercises everything together.
module tb_acc_alu_seq;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         RESET, START, SET;
  logic [3:0]   OP;
  logic [W-1:0] SETNUM, INPUT;
  logic [W-1:0] OUT, HI;
  logic         SC_OUT, ZERO, EQ, LT, GT, BUSY, DONE;

  int checks   = 0;
  int failures = 0;

  acc_alu_seq #(.W(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .OP    (OP),
    .SET   (SET),
    .SETNUM(SETNUM),
    .INPUT (INPUT),
    .OUT   (OUT),
    .HI    (HI),
    .SC_OUT(SC_OUT),
    .ZERO  (ZERO),
    .EQ    (EQ),
    .LT    (LT),
    .GT    (GT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  // Model state: architectural values plus one pending multi-cycle result
  int m_r0, m_c, m_out, m_hi, m_eq, m_lt, m_gt, m_done;
  int pend_left;
  int p_r0, p_c, p_hi;
  bit p_mul;
  bit model_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Results of an accepted START computed straight from the op definitions
  task automatic model_op(input int op, input int b);
    int s, n;
    m_done = 1;
    case (op)
      1: begin m_r0 = b; m_out = b; end
      2: m_out = m_r0;
      3: begin s = m_r0 + b + m_c; m_r0 = s & MASK; m_c = (s >> W) & 1; m_out = m_r0; end
      4: begin s = m_r0 + ((~b) & MASK) + 1; m_r0 = s & MASK; m_c = (s >> W) & 1; m_out = m_r0; end
      5: begin m_r0 = m_r0 & b; m_out = m_r0; end
      6: begin m_r0 = m_r0 ^ b; m_out = m_r0; end
      7: begin s = (m_r0 << 1) | m_c; m_r0 = s & MASK; m_c = (s >> W) & 1; m_out = m_r0; end
      8: begin s = m_c; m_c = m_r0 & 1; m_r0 = (s << (W - 1)) | (m_r0 >> 1); m_out = m_r0; end
      9, 10: begin
        n = (b > W) ? W : b;
        if (n > 0) begin
          m_done = 0; pend_left = n; p_mul = 0;
          if (op == 9) begin s = m_r0 << n; p_r0 = s & MASK; p_c = (s >> W) & 1; end
          else begin p_r0 = m_r0 >> n; p_c = (m_r0 >> (n - 1)) & 1; end
        end
      end
      11: begin
        s = m_r0 * b; p_r0 = s & MASK; p_hi = (s >> W) & MASK; p_c = 0;
        p_mul = 1; pend_left = W; m_done = 0;
      end
      12: begin m_eq = (m_r0 == b); m_lt = (m_r0 < b); m_gt = (m_r0 > b); end
      13: m_c = 0;
      14: m_c = 1;
      default: ;
    endcase
  endtask

  // Model update on each rising edge, from the inputs present at that edge
  always @(posedge CLK) begin
    if (RESET) begin
      m_r0 = 0; m_c = 0; m_out = 0; m_hi = 0;
      m_eq = 0; m_lt = 0; m_gt = 0; m_done = 0;
      pend_left = 0; model_valid = 1'b1;
    end else if (model_valid) begin
      m_done = 0;
      if (pend_left > 0) begin
        pend_left--;
        if (pend_left == 0) begin
          m_r0 = p_r0; m_out = p_r0; m_c = p_c; m_done = 1;
          if (p_mul) m_hi = p_hi;
        end
      end else if (SET) begin
        m_r0 = int'(SETNUM);
      end else if (START) begin
        model_op(int'(OP), int'(INPUT));
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge CLK) begin
    if (model_valid) begin
      checkOutput("cyc OUT",  32'(OUT),    m_out);
      checkOutput("cyc HI",   32'(HI),     m_hi);
      checkOutput("cyc C",    32'(SC_OUT), m_c);
      checkOutput("cyc ZERO", 32'(ZERO),   (m_r0 == 0) ? 1 : 0);
      checkOutput("cyc EQ",   32'(EQ),     m_eq);
      checkOutput("cyc LT",   32'(LT),     m_lt);
      checkOutput("cyc GT",   32'(GT),     m_gt);
      checkOutput("cyc BUSY", 32'(BUSY),   (pend_left > 0) ? 1 : 0);
      checkOutput("cyc DONE", 32'(DONE),   m_done);
    end
  end

  // Drive one cycle of inputs, let the edge happen, then drop the strobes
  task automatic applyStimulus(input bit set, input int setnum, input bit start, input int op, input int inp);
    SET    = set;
    SETNUM = W'(setnum);
    START  = start;
    OP     = 4'(op);
    INPUT  = W'(inp);
    @(posedge CLK);
    #1;
    SET   = 1'b0;
    START = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; SET = 1'b0; OP = '0; SETNUM = '0; INPUT = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst OUT",  32'(OUT),    0);
    checkOutput("rst HI",   32'(HI),     0);
    checkOutput("rst C",    32'(SC_OUT), 0);
    checkOutput("rst ZERO", 32'(ZERO),   1);
    checkOutput("rst BUSY", 32'(BUSY),   0);
    checkOutput("rst DONE", 32'(DONE),   0);
    RESET = 1'b0;

    // ADD chain with carry in and out
    applyStimulus(1, 'hF0, 0, 0, 0);
    applyStimulus(0, 0, 1, 3, 'h20);
    checkOutput("add1 OUT",  32'(OUT),    'h10);
    checkOutput("add1 C",    32'(SC_OUT), 1);
    checkOutput("add1 DONE", 32'(DONE),   1);
    applyStimulus(0, 0, 1, 3, 'h00);
    checkOutput("add2 OUT", 32'(OUT),    'h11);
    checkOutput("add2 C",   32'(SC_OUT), 0);

    // SUB with borrow, then CMP
    applyStimulus(1, 'h05, 0, 0, 0);
    applyStimulus(0, 0, 1, 4, 'h07);
    checkOutput("sub OUT", 32'(OUT),    'hFE);
    checkOutput("sub C",   32'(SC_OUT), 0);
    applyStimulus(0, 0, 1, 12, 'hFF);
    checkOutput("cmp LT", 32'(LT), 1);
    checkOutput("cmp EQ", 32'(EQ), 0);
    checkOutput("cmp GT", 32'(GT), 0);

    // MUL 0xFF*0xFF with an ignored ADD in the middle
    applyStimulus(1, 'hFF, 0, 0, 0);
    applyStimulus(0, 0, 1, 11, 'hFF);
    checkOutput("mul BUSY0", 32'(BUSY), 1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, (i == 4), 3, 'h11);
      if (i < 8) begin
        checkOutput("mul BUSY", 32'(BUSY), 1);
        checkOutput("mul DONE", 32'(DONE), 0);
      end else begin
        checkOutput("mul end DONE", 32'(DONE), 1);
        checkOutput("mul end BUSY", 32'(BUSY), 0);
        checkOutput("mul HI",       32'(HI),   'hFE);
        checkOutput("mul OUT",      32'(OUT),  'h01);
      end
    end
    applyStimulus(0, 0, 0, 0, 0);

    // Shifts: SHLN 3, SHRN 0, SHLN 9
    applyStimulus(1, 'h81, 0, 0, 0);
    applyStimulus(0, 0, 1, 9, 3);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("shl3 BUSY", 32'(BUSY), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("shl3 OUT",  32'(OUT),    'h08);
    checkOutput("shl3 C",    32'(SC_OUT), 0);
    checkOutput("shl3 DONE", 32'(DONE),   1);
    applyStimulus(0, 0, 1, 10, 0);
    checkOutput("shr0 DONE", 32'(DONE), 1);
    checkOutput("shr0 BUSY", 32'(BUSY), 0);
    checkOutput("shr0 OUT",  32'(OUT),  'h08);
    applyStimulus(0, 0, 1, 9, 9);
    repeat (8) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("shl9 OUT",  32'(OUT),  'h00);
    checkOutput("shl9 ZERO", 32'(ZERO), 1);
    checkOutput("shl9 DONE", 32'(DONE), 1);

    // SET does not touch OUT; ASSIGN copies R0 into it
    applyStimulus(1, 'h3C, 0, 0, 0);
    checkOutput("set OUT",  32'(OUT),  'h00);
    checkOutput("set ZERO", 32'(ZERO), 0);
    applyStimulus(0, 0, 1, 2, 0);
    checkOutput("assign OUT", 32'(OUT), 'h3C);

    // Reset in the middle of a MUL
    applyStimulus(1, 'h03, 0, 0, 0);
    applyStimulus(0, 0, 1, 11, 'h05);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    RESET = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    RESET = 1'b0;
    checkOutput("abort BUSY", 32'(BUSY), 0);
    checkOutput("abort OUT",  32'(OUT),  0);
    checkOutput("abort HI",   32'(HI),   0);
    checkOutput("abort ZERO", 32'(ZERO), 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("abort DONE", 32'(DONE), 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      RESET = ($urandom_range(0, 299) == 0);
      applyStimulus($urandom_range(0, 7) == 0, int'($urandom), $urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : int'($urandom));
    end
    RESET = 1'b0;
    repeat (12) applyStimulus(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_alu_seq.md
# acc_alu_seq

Parametrised, clocked accumulator ALU for the CSE141L datapath. It is the successor to the combinational 8-bit ALU. The accumulator R0, the carry flag and the compare flags are registered inside the block. It adds multi-cycle N-bit shifts and an unsigned multiply behind a START/BUSY/DONE handshake. It sits between the register file read port and the writeback mux; the controller sequences it from the decoded opcode.

## Interface
- W, default 8: datapath width, must be ≥ 4.
- CLK, input, 1: clock; all state updates on the rising edge.
- RESET, input, 1: synchronous, active-high reset.
- START, input, 1: issue OP this cycle; accepted only when BUSY=0.
- OP, input, 4: operation code (see Operation).
- SET, input, 1: load R0 from SETNUM; accepted only when BUSY=0.
- SETNUM, input, W: immediate for SET.
- INPUT, input, W: second operand; sampled at the accepting edge only.
- OUT, output, W: registered result, equal to R0 after every R0-writing op.
- HI, output, W: upper half of the last MUL result.
- SC_OUT, output, 1: registered carry flag C.
- ZERO, output, 1: combinational, (R0 == 0).
- EQ, LT, GT, output, 1 each: registered unsigned compare flags of R0 vs INPUT.
- BUSY, output, 1: high while a multi-cycle op is in progress.
- DONE, output, 1: one-cycle pulse when an op's result is visible.

## Operation
- Reset values: R0, OUT, HI = 0; C, EQ, LT, GT, BUSY, DONE = 0; ZERO = 1; state IDLE.
- Priority in IDLE: RESET, then SET, then START.
  - SET: R0 ← SETNUM, with no DONE and no flag change.
  - START in the same cycle as SET is dropped.
- Single-cycle opcodes (DONE in the next cycle, BUSY stays 0):
  - 0 NOP.
  - 1 MOVE: R0 ← INPUT.
  - 2 ASSIGN: OUT ← R0.
  - 3 ADD: {C,R0} ← R0 + INPUT + C.
  - 4 SUB: {C,R0} ← R0 + ~INPUT + 1; C = 1 means no borrow.
  - 5 AND: R0 ← R0 & INPUT.
  - 6 XOR: R0 ← R0 ^ INPUT.
  - 7 LSL1: {C,R0} ← {R0,C}.
  - 8 LSR1: {R0,C} ← {C,R0}.
  - 12 CMP: EQ/LT/GT ← R0 ==/</> INPUT, unsigned; R0 unchanged.
  - 13 CLRC: C ← 0.
  - 14 SETC: C ← 1.
  - 15: treated as NOP.
- Multi-cycle opcodes, N steps:
  - 9 SHLN: shift left with zero fill; N = min(INPUT, W).
  - 10 SHRN: logical shift right; N = min(INPUT, W).
  - C ← the last bit shifted out.
  - N = 0: R0 and C unchanged, completes as a single-cycle op.
  - 11 MUL: unsigned shift-add; N = W; {HI,R0} ← R0 × INPUT; C ← 0.
- Multi-cycle ops work in shadow registers. R0, HI and C are written only at completion, so intermediate values are never visible.
- AND, XOR, MOVE, SHLN, SHRN and MUL leave C unchanged except as stated above. Only CMP writes EQ/LT/GT.
- FSM states:
  - IDLE → EXEC on a multi-cycle START with N > 0.
  - EXEC counts N steps, then moves to IDLE and pulses DONE.
  - Step counter width is $clog2(W)+1.
- START or SET while BUSY=1: ignored, not queued, no effect.
- RESET during EXEC: aborts the op, all outputs take reset values, and no DONE is produced.

## Timing
- Single-cycle op accepted at edge k: R0/OUT/C/flags valid after edge k; DONE=1 for the cycle between edges k and k+1.
- Multi-cycle op accepted at edge k:
  - BUSY=1 from after edge k until after edge k+N.
  - Result and DONE=1 appear after edge k+N; DONE lasts one cycle.
  - BUSY falls on the same edge that DONE rises.
  - A new START is accepted at edge k+N+1 at the earliest, while DONE is high.
- MUL latency at W=8: 8 cycles, then DONE.
- Back-to-back single-cycle STARTs are accepted every cycle; DONE stays high continuously.
- ZERO tracks R0 combinationally; it has no registered lag.

## Test plan
- Reset: assert RESET for 2 cycles → R0=0, C=0, ZERO=1, BUSY=0, DONE=0.
- ADD chain at W=8:
  - SET 0xF0, then ADD 0x20 → R0=0x10, C=1, DONE next cycle.
  - Then ADD 0x00 → R0=0x11, C=0.
- SUB and CMP:
  - SET 0x05, then SUB 0x07 → R0=0xFE, C=0.
  - Then CMP 0xFF → LT=1, EQ=0, GT=0.
- MUL:
  - SET 0xFF, then MUL 0xFF → BUSY high for 8 cycles; DONE after edge k+8; HI=0xFE, R0=0x01.
  - START ADD issued mid-MUL is ignored.
- Shifts:
  - SET 0x81, SHLN 3 → R0=0x08, C=0, completes after 3 cycles.
  - SHRN 0 → R0 unchanged, DONE next cycle.
  - SHLN 9 → R0=0x00 after 8 cycles.
- Reset mid-op: RESET at cycle 4 of a MUL → BUSY=0, R0=0, HI=0, and no DONE pulse in the following 10 cycles.
